// File: rtl/dll_tx_lcrc_sched.sv
// Data-link-layer transmit scheduler: tags TLPs with a sequence number, waits out
// the LCRC unit latency, hands protected packets downstream and tracks the replay window.
module dll_tx_lcrc_sched #(
  parameter int TLP_WIDTH       = 128,
  parameter int LCRC_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TLP_WIDTH-1:0]   tlp_in,
  input  logic                   tlp_valid,
  output logic                   tlp_ready,
  output logic [TLP_WIDTH+15:0]  crc_in,
  input  logic [TLP_WIDTH+47:0]  crc_out,
  output logic [TLP_WIDTH+47:0]  tx_data,
  output logic [11:0]            tx_seq,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   ack_valid,
  input  logic [11:0]            ack_seq,
  output logic                   ack_err,
  output logic [11:0]            outstanding,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t      state, state_nxt;
  logic [11:0] next_seq;
  logic [11:0] acked_seq;
  logic [11:0] freed;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        tx_fire;
  logic        ack_ok;
  logic        ack_bad;

  // ACK distance is taken modulo 4096 so the window survives sequence wrap
  assign freed   = ack_seq - acked_seq;
  assign ack_ok  = ack_valid && (freed != '0) && (freed <= outstanding);
  assign ack_bad = ack_valid && (freed > outstanding);

  always_comb begin
    tlp_ready = (state == IDLE) && (outstanding < 12'(MAX_OUTSTANDING));
    accept    = tlp_valid && tlp_ready;
    tx_fire   = (state == SEND) && tx_valid && tx_ready;
    busy      = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = SEND;
      SEND:    if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      next_seq    <= '0;
      acked_seq   <= '1;
      outstanding <= '0;
      crc_in      <= '0;
      tx_data     <= '0;
      tx_seq      <= '0;
      tx_valid    <= 1'b0;
      ack_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (accept) begin
        crc_in   <= {4'b0000, next_seq, tlp_in};
        tx_seq   <= next_seq;
        wait_cnt <= 4'(LCRC_LATENCY - 1);
      end
      if (state == WAIT) begin
        if (wait_cnt == '0) begin
          tx_data  <= crc_out;
          tx_valid <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
      if (tx_fire) begin
        tx_valid <= 1'b0;
        next_seq <= next_seq + 12'd1;
      end
      if (ack_ok) acked_seq <= ack_seq;
      // Window check used the pre-increment count; both adjustments land together
      outstanding <= outstanding + {11'd0, tx_fire} - (ack_ok ? freed : 12'd0);
      ack_err     <= ack_bad;
    end
  end

endmodule

// File: tb/tb_dll_tx_lcrc_sched.sv
// Directed bench for dll_tx_lcrc_sched: per-cycle vector table plus hand sequences
// for backpressure, window full, wrap-around, simultaneous ACK and mid-flight reset.
module tb_dll_tx_lcrc_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] tlp_in;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [143:0] crc_in;
  logic [175:0] crc_out;
  logic [175:0] tx_data;
  logic [11:0]  tx_seq;
  logic         tx_valid;
  logic         tx_ready;
  logic         ack_valid;
  logic [11:0]  ack_seq;
  logic         ack_err;
  logic [11:0]  outstanding;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] lcrc32(input logic [143:0] d);
    logic [31:0] c;
    logic        fb;
    c = '1;
    for (int i = 143; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return ~c;
  endfunction

  function automatic logic [175:0] pkt(input logic [127:0] d, input logic [11:0] s);
    logic [143:0] c;
    c = {4'h0, s, d};
    return {c, lcrc32(c)};
  endfunction

  // LCRC unit model for latency 1: result available the cycle after crc_in updates
  assign crc_out = {crc_in, lcrc32(crc_in)};

  dll_tx_lcrc_sched #(
    .TLP_WIDTH(128),
    .LCRC_LATENCY(1),
    .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tlp_in(tlp_in),
    .tlp_valid(tlp_valid),
    .tlp_ready(tlp_ready),
    .crc_in(crc_in),
    .crc_out(crc_out),
    .tx_data(tx_data),
    .tx_seq(tx_seq),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ack_valid(ack_valid),
    .ack_seq(ack_seq),
    .ack_err(ack_err),
    .outstanding(outstanding),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; tlp_valid = 1'b0; tlp_in = '0; tx_ready = 1'b0;
    ack_valid = 1'b0; ack_seq = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One TLP end to end with tx_ready high; starts and ends at a negedge
  task automatic send_tlp(input logic [127:0] d, input logic [11:0] s, input logic [11:0] exp_out);
    tlp_valid = 1'b1; tlp_in = d; tx_ready = 1'b1;
    chk("send_tlp_ready", tlp_ready, 1);
    @(negedge clk);
    tlp_valid = 1'b0;
    chk("send_busy", busy, 1);
    chk("send_crc_in", crc_in, {4'h0, s, d});
    @(negedge clk);
    chk("send_tx_valid", tx_valid, 1);
    chk("send_tx_seq", tx_seq, s);
    chk("send_tx_data", tx_data, pkt(d, s));
    @(negedge clk);
    chk("send_tx_done", tx_valid, 0);
    chk("send_outstanding", outstanding, exp_out);
  endtask

  typedef struct {
    logic         tv;
    logic [127:0] tlp;
    logic         trdy;
    logic         av;
    logic [11:0]  aseq;
    logic         e_rdy;
    logic         e_txv;
    logic [11:0]  e_seq;
    logic [11:0]  e_out;
    logic         e_err;
    logic         e_busy;
  } vec_t;

  vec_t vt[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, c, last;
    a = 128'h0123456789ABCDEF_FEDCBA9876543210;
    b = 128'hDEADBEEFCAFEF00D_0000111122223333;
    c = 128'h5A5A5A5AA5A5A5A5_0F0F0F0FF0F0F0F0;

    //           tv    tlp     trdy  av    aseq      rdy   txv   seq    out    err   busy
    vt[0]  = '{1'b1, a,      1'b1, 1'b0, 12'd0,    1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 128'd0, 1'b1, 1'b0, 12'd0,    1'b0, 1'b1, 12'd0, 12'd0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 128'd0, 1'b1, 1'b0, 12'd0,    1'b1, 1'b0, 12'd0, 12'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, b,      1'b0, 1'b0, 12'd0,    1'b0, 1'b0, 12'd1, 12'd1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 128'd0, 1'b0, 1'b0, 12'd0,    1'b0, 1'b1, 12'd1, 12'd1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 128'd0, 1'b1, 1'b0, 12'd0,    1'b1, 1'b0, 12'd1, 12'd2, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 128'd0, 1'b0, 1'b1, 12'd5,    1'b1, 1'b0, 12'd1, 12'd2, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 128'd0, 1'b0, 1'b1, 12'd4095, 1'b1, 1'b0, 12'd1, 12'd2, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 128'd0, 1'b0, 1'b1, 12'd1,    1'b1, 1'b0, 12'd1, 12'd0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 128'd0, 1'b0, 1'b1, 12'd1,    1'b1, 1'b0, 12'd1, 12'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 128'd0, 1'b0, 1'b1, 12'd2,    1'b1, 1'b0, 12'd1, 12'd0, 1'b1, 1'b0};

    reset = 1'b0; tlp_valid = 1'b0; tlp_in = '0; tx_ready = 1'b0;
    ack_valid = 1'b0; ack_seq = '0;

    // Reset state
    do_reset();
    chk("rst_tlp_ready", tlp_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_seq", tx_seq, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_crc_in", crc_in, 0);
    chk("rst_tx_data", tx_data, 0);

    // Per-cycle vector table: two TLPs, then the ACK window cases
    last = '0;
    for (int i = 0; i < 11; i++) begin
      tlp_valid = vt[i].tv; tlp_in = vt[i].tlp; tx_ready = vt[i].trdy;
      ack_valid = vt[i].av; ack_seq = vt[i].aseq;
      if (vt[i].tv) last = vt[i].tlp;
      @(negedge clk);
      chk($sformatf("vec%0d_tlp_ready", i), tlp_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vt[i].e_txv);
      chk($sformatf("vec%0d_tx_seq", i), tx_seq, vt[i].e_seq);
      chk($sformatf("vec%0d_outstanding", i), outstanding, vt[i].e_out);
      chk($sformatf("vec%0d_ack_err", i), ack_err, vt[i].e_err);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      if (vt[i].e_txv) chk($sformatf("vec%0d_tx_data", i), tx_data, pkt(last, vt[i].e_seq));
    end
    ack_valid = 1'b0;

    // Zero TLP: LCRC of all-zero header+payload
    do_reset();
    send_tlp(128'h0, 12'd0, 12'd1);

    // Fill the window, hold off, reopen with an ACK
    do_reset();
    for (int i = 0; i < 8; i++) send_tlp(128'(i) ^ c, 12'(i), 12'(i + 1));
    chk("full_tlp_ready", tlp_ready, 0);
    chk("full_outstanding", outstanding, 8);
    tlp_valid = 1'b1; tlp_in = c;
    @(negedge clk);
    chk("full_no_accept", busy, 0);
    chk("full_still_blocked", tlp_ready, 0);
    tlp_valid = 1'b0; ack_valid = 1'b1; ack_seq = 12'd3;
    @(negedge clk);
    ack_valid = 1'b0;
    chk("reopen_outstanding", outstanding, 4);
    chk("reopen_tlp_ready", tlp_ready, 1);
    send_tlp(b, 12'd8, 12'd5);

    // Backpressure: 5 cycles of tx_ready low in SEND with a TLP waiting
    do_reset();
    tlp_valid = 1'b1; tlp_in = c; tx_ready = 1'b0;
    @(negedge clk);
    tlp_valid = 1'b0;
    @(negedge clk);
    chk("bp_tx_valid_rise", tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tlp_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp%0d_tx_valid", i), tx_valid, 1);
      chk($sformatf("bp%0d_tx_data", i), tx_data, pkt(c, 12'd0));
      chk($sformatf("bp%0d_tx_seq", i), tx_seq, 0);
      chk($sformatf("bp%0d_outstanding", i), outstanding, 0);
      chk($sformatf("bp%0d_tlp_ready", i), tlp_ready, 0);
    end
    tlp_valid = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_valid", tx_valid, 0);
    chk("bp_handshake_out", outstanding, 1);

    // Stream with per-TLP ACKs until next_seq reaches 4094
    do_reset();
    tx_ready = 1'b1;
    for (int s = 0; s < 4094; s++) begin
      tlp_valid = 1'b1; tlp_in = 128'(s);
      @(negedge clk);
      tlp_valid = 1'b0;
      repeat (2) @(negedge clk);
      ack_valid = 1'b1; ack_seq = 12'(s);
      @(negedge clk);
      ack_valid = 1'b0;
    end
    chk("stream_last_seq", tx_seq, 4093);
    chk("stream_outstanding", outstanding, 0);
    send_tlp(a, 12'd4094, 12'd1);
    send_tlp(b, 12'd4095, 12'd2);
    send_tlp(c, 12'd0, 12'd3);
    ack_valid = 1'b1; ack_seq = 12'd0;
    @(negedge clk);
    ack_valid = 1'b0;
    chk("wrap_ack_outstanding", outstanding, 0);
    chk("wrap_ack_err", ack_err, 0);

    // ACK coinciding with the tx handshake
    do_reset();
    send_tlp(a, 12'd0, 12'd1);
    send_tlp(b, 12'd1, 12'd2);
    send_tlp(c, 12'd2, 12'd3);
    tlp_valid = 1'b1; tlp_in = a; tx_ready = 1'b0;
    @(negedge clk);
    tlp_valid = 1'b0;
    @(negedge clk);
    chk("simul_tx_valid", tx_valid, 1);
    chk("simul_tx_seq", tx_seq, 3);
    chk("simul_pre_out", outstanding, 3);
    tx_ready = 1'b1; ack_valid = 1'b1; ack_seq = 12'd1;
    @(negedge clk);
    ack_valid = 1'b0;
    chk("simul_outstanding", outstanding, 2);
    chk("simul_tx_done", tx_valid, 0);
    chk("simul_ack_err", ack_err, 0);

    // Reset while in WAIT drops the in-flight TLP
    tlp_valid = 1'b1; tlp_in = b;
    @(negedge clk);
    tlp_valid = 1'b0;
    chk("midrst_in_wait", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_tx_seq", tx_seq, 0);
    chk("midrst_crc_in", crc_in, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_no_resend", tx_valid, 0);
    chk("midrst_idle", busy, 0);
    send_tlp(c, 12'd0, 12'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dll_tx_lcrc_sched.md
Name: dll_tx_lcrc_sched

Overview:
Data-link-layer transmit scheduler that sequences the LCRC generator. It accepts TLPs from the transaction layer and prepends the 12-bit sequence-number header. It drives the LCRC unit, waits out its latency, then presents the protected packet to the link/replay-buffer side. It also enforces the replay window by counting unacknowledged TLPs, and retires them on ACK DLLPs.

Parameters:
TLP_WIDTH, 128, TLP payload bits; TLP_WIDTH+16 must be a multiple of 8.
LCRC_LATENCY, 1, cycles from crc_in update to crc_out valid; legal range 1..15.
MAX_OUTSTANDING, 8, replay-buffer capacity in TLPs; legal range 1..2048.

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
tlp_in  in  TLP_WIDTH  TLP from transaction layer
tlp_valid  in  1  tlp_in valid
tlp_ready  out  1  scheduler can accept a TLP this cycle
crc_in  out  TLP_WIDTH+16  to LCRC unit: {4'b0000, seq[11:0], tlp}
crc_out  in  TLP_WIDTH+48  from LCRC unit: {crc_in, lcrc[31:0]}
tx_data  out  TLP_WIDTH+48  protected packet to link / replay buffer
tx_seq  out  12  sequence number carried in tx_data
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts tx_data
ack_valid  in  1  ACK DLLP received
ack_seq  in  12  AckNak_Seq_Num of the ACK
ack_err  out  1  one-cycle pulse: ACK outside the outstanding window
outstanding  out  12  unacknowledged TLP count
busy  out  1  state != IDLE

Behaviour:
- Reset, while reset==0 at posedge: state=IDLE; next_seq=0; acked_seq=4095; outstanding=0; crc_in=0; tx_data=0; tx_seq=0; tx_valid=0; ack_err=0. Reset mid-operation discards the in-flight TLP; it is not retransmitted.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - tlp_ready = (state==IDLE) && (outstanding < MAX_OUTSTANDING); combinational.
  - On tlp_valid && tlp_ready: crc_in <= {4'b0000, next_seq, tlp_in}; tx_seq <= next_seq; wait_cnt <= LCRC_LATENCY-1; go to WAIT.
- WAIT:
  - crc_in is held stable throughout.
  - If wait_cnt==0: tx_data <= crc_out; tx_valid <= 1; go to SEND.
  - Otherwise decrement wait_cnt.
  - Accept-to-tx_valid latency is LCRC_LATENCY+1 cycles.
- SEND:
  - tx_valid, tx_data and tx_seq are held until tx_ready.
  - On tx_valid && tx_ready: tx_valid <= 0; next_seq <= (next_seq+1) mod 4096; outstanding increments; go to IDLE.
  - The earliest next accept is the cycle after the handshake. Throughput is 1 TLP per LCRC_LATENCY+2 cycles.
- ACK handling, evaluated every cycle in any state:
  - freed = (ack_seq - acked_seq) mod 4096.
  - If ack_valid && 1 <= freed <= outstanding: acked_seq <= ack_seq; outstanding decrements by freed.
  - If ack_valid && freed==0: duplicate ACK; no-op, no error.
  - If ack_valid && freed > outstanding: ignored; ack_err pulses for 1 cycle.
  - The comparison uses the registered outstanding value, before this cycle's tx increment.
- Simultaneous tx handshake and valid ACK: outstanding <= outstanding + 1 - freed.
- Full: while outstanding == MAX_OUTSTANDING, tlp_ready=0. A TLP already in WAIT or SEND still completes. A valid ACK reopens tlp_ready the following cycle.
- Wrap-around: sequence numbers and ACK arithmetic are modulo 4096. next_seq=4095 is followed by 0.
- crc_out is sampled only at the WAIT-exit edge; its value at other times is ignored.

Test Plan:
1. Reset, then tlp_in=128'h0, valid for 1 cycle, tx_ready=1 -> crc_in={16'h0000,128'h0}; tx_valid at accept+2 with tx_seq=0; tx_data[31:0] equals the LCRC of crc_in; outstanding=1.
2. Back-to-back TLPs, tx_ready=1, with MAX_OUTSTANDING=8 and no ACKs -> tx_seq 0..7 emitted, then tlp_ready=0 and outstanding=8. ack_seq=3 -> outstanding=4, tlp_ready=1 next cycle, next TLP carries tx_seq=8.
3. tx_ready held low 5 cycles in SEND -> tx_valid, tx_data and tx_seq stable; no new accept; outstanding unchanged until the handshake.
4. ACK checks with outstanding=2 (seq 0,1), acked_seq=4095:
   - ack_seq=5 -> ack_err pulse; state unchanged.
   - ack_seq=4095 -> no-op, no ack_err.
   - ack_seq=1 -> outstanding=0.
5. Wrap: drive next_seq to 4094 by streaming with ACKs, send 3 TLPs -> tx_seq 4094, 4095, 0. ack_seq=0 with acked_seq=4093 -> freed=3, outstanding drops by 3.
6. ACK in the same cycle as the tx handshake (outstanding=3, freed=2) -> outstanding=2. Separately, reset asserted in WAIT -> tx_valid stays 0, next_seq=0, outstanding=0, busy=0.
